// File: rtl/vgacon_pkg.sv
// Shared definitions for the VGA text console: sequencer states,
// control character codes and the default screen geometry.
package vgacon_pkg;

  localparam int unsigned VGA_COLS = 12;
  localparam int unsigned VGA_ROWS = 3;

  localparam logic [6:0] CH_CR    = 7'h0D;
  localparam logic [6:0] CH_LF    = 7'h0A;
  localparam logic [6:0] CH_BS    = 7'h08;
  localparam logic [6:0] CH_BLANK = 7'h20;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_COPY,
    ST_FILL,
    ST_CLEAR
  } state_t;

endpackage

// File: rtl/vgacon_term_ctrl_if.sv
// Character stream handshake plus text buffer write/read port.
// master: character source and text RAM; slave: the terminal sequencer.
interface vgacon_term_ctrl_if;
  logic       in_valid;
  logic [6:0] in_char;
  logic       in_ready;
  logic       buf_we;
  logic [5:0] buf_addr;
  logic [6:0] buf_wdata;
  logic [5:0] buf_raddr;
  logic [6:0] buf_rdata;

  modport master (
    output in_valid, in_char, buf_rdata,
    input  in_ready, buf_we, buf_addr, buf_wdata, buf_raddr
  );

  modport slave (
    input  in_valid, in_char, buf_rdata,
    output in_ready, buf_we, buf_addr, buf_wdata, buf_raddr
  );
endinterface

// File: rtl/vgacon_term_ctrl.sv
// Terminal-style write sequencer for the text console buffer: writes
// printable characters at the cursor, handles CR/LF/BS, wraps lines and
// scrolls by copying rows up through the buffer read port.
module vgacon_term_ctrl
  import vgacon_pkg::*;
#(
  parameter int unsigned COLS  = VGA_COLS,
  parameter int unsigned ROWS  = VGA_ROWS,
  parameter logic [6:0]  BLANK = CH_BLANK
) (
  input  logic               clk,
  input  logic               reset,
  vgacon_term_ctrl_if.slave  bus,
  input  logic               clear,
  output logic [5:0]         cursor_pos,
  output logic               busy
);

  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [5:0]    COLS6      = 6'(COLS);
  localparam logic [5:0]    COPY_LAST  = 6'((ROWS - 1) * COLS - 1);
  localparam logic [5:0]    FILL_FIRST = 6'((ROWS - 1) * COLS);
  localparam logic [5:0]    CELL_LAST  = 6'(ROWS * COLS - 1);

  state_t          state;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic [5:0]      cnt;
  logic [6:0]      ch;
  logic            adv;   // WRITE advances the cursor (printable) or not (BS blank)
  logic            printable;

  assign printable    = (bus.in_char >= 7'h20) && (bus.in_char <= 7'h7E);
  assign cursor_pos   = 6'(row) * COLS6 + 6'(col);
  assign busy         = (state != ST_IDLE);
  assign bus.in_ready = (state == ST_IDLE) && !clear;

  // Sequencer state, cursor, counter and latched character.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
      row   <= '0;
      col   <= '0;
      cnt   <= '0;
      ch    <= BLANK;
      adv   <= 1'b0;
    end else if (clear && state != ST_INIT) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      row   <= '0;
      col   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          state <= ST_CLEAR;
          cnt   <= '0;
          row   <= '0;
          col   <= '0;
        end
        ST_IDLE: begin
          // clear was handled above, so in_ready is high here and
          // in_valid alone marks a handshake
          if (bus.in_valid) begin
            if (printable) begin
              ch    <= bus.in_char;
              adv   <= 1'b1;
              state <= ST_WRITE;
            end else if (bus.in_char == CH_CR) begin
              col <= '0;
            end else if (bus.in_char == CH_LF) begin
              col <= '0;
              if (row != ROW_LAST) begin
                row <= row + 1'b1;
              end else begin
                state <= ST_COPY;
                cnt   <= '0;
              end
            end else if (bus.in_char == CH_BS) begin
              // step back first so WRITE blanks the new cell in place
              if (col != '0) begin
                col   <= col - 1'b1;
                ch    <= BLANK;
                adv   <= 1'b0;
                state <= ST_WRITE;
              end
            end
          end
        end
        ST_WRITE: begin
          if (!adv) begin
            state <= ST_IDLE;
          end else if (col != COL_LAST) begin
            col   <= col + 1'b1;
            state <= ST_IDLE;
          end else begin
            col <= '0;
            if (row != ROW_LAST) begin
              row   <= row + 1'b1;
              state <= ST_IDLE;
            end else begin
              state <= ST_COPY;
              cnt   <= '0;
            end
          end
        end
        ST_COPY: begin
          if (cnt == COPY_LAST) begin
            state <= ST_FILL;
            cnt   <= FILL_FIRST;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FILL: begin
          if (cnt == CELL_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
            row   <= ROW_LAST;
            col   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CLEAR: begin
          if (cnt == CELL_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Buffer port drive, from registered state, counter and read data only.
  always_comb begin
    bus.buf_we    = 1'b0;
    bus.buf_addr  = '0;
    bus.buf_wdata = BLANK;
    bus.buf_raddr = '0;
    case (state)
      ST_WRITE: begin
        bus.buf_we    = 1'b1;
        bus.buf_addr  = cursor_pos;
        bus.buf_wdata = ch;
      end
      ST_COPY: begin
        bus.buf_raddr = cnt + COLS6;
        bus.buf_we    = 1'b1;
        bus.buf_addr  = cnt;
        bus.buf_wdata = bus.buf_rdata;
      end
      ST_FILL, ST_CLEAR: begin
        bus.buf_we    = 1'b1;
        bus.buf_addr  = cnt;
        bus.buf_wdata = BLANK;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vgacon_term_ctrl.sv
// Directed bench for the terminal write sequencer with a behavioural
// text RAM and a log of every buffer write.
module tb_vgacon_term_ctrl;

  logic       clk;
  logic       reset;
  logic       clear;
  logic [5:0] cursor_pos;
  logic       busy;

  vgacon_term_ctrl_if bus ();

  vgacon_term_ctrl #(
    .COLS  (12),
    .ROWS  (3),
    .BLANK (7'h20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .clear      (clear),
    .cursor_pos (cursor_pos),
    .busy       (busy)
  );

  logic [6:0]  mem [0:63];
  int unsigned cyc;
  int unsigned log_addr [$];
  int unsigned log_data [$];
  int unsigned log_cyc  [$];
  int unsigned n_checks;
  int unsigned n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.buf_rdata = mem[bus.buf_raddr];

  always @(negedge clk) begin
    if (bus.buf_we === 1'b1) begin
      mem[bus.buf_addr] <= bus.buf_wdata;
      log_addr.push_back(int'(bus.buf_addr));
      log_data.push_back(int'(bus.buf_wdata));
      log_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic log_reset();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic chk_entry(input string tag, input int unsigned idx,
                           input int unsigned addr, input int unsigned data);
    if (idx < log_addr.size()) begin
      chk({tag, "_addr"}, log_addr[idx], addr);
      chk({tag, "_data"}, log_data[idx], data);
    end else begin
      chk({tag, "_missing"}, log_addr.size(), idx + 1);
    end
  endtask

  // Called #1 after an edge; counts edges until in_ready is high.
  task automatic wait_ready(input int unsigned limit, output int unsigned n);
    n = 0;
    while (!bus.in_ready && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= limit) chk("ready_timeout", 32'(bus.in_ready), 1);
  endtask

  // Offers c until accepted; hs is the cycle count just before the accepting edge.
  task automatic send(input logic [6:0] c, output int unsigned hs);
    int unsigned w;
    bus.in_char  = c;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 200) chk("send_timeout", 32'(bus.in_ready), 1);
    hs = cyc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int unsigned n, h, h1, h2;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 7'h7F;
    reset        = 1'b1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_char  = 7'h00;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 32'(bus.buf_we), 0);
    chk("rst_ready", 32'(bus.in_ready), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_cursor", 32'(cursor_pos), 0);

    // release: one INIT cycle then 36 blanking writes
    log_reset();
    reset = 1'b0;
    wait_ready(100, n);
    chk("init_ready_edges", n, 37);
    chk("init_busy", 32'(busy), 0);
    chk("init_cursor", 32'(cursor_pos), 0);
    chk("init_nwrites", log_addr.size(), 36);
    for (int k = 0; k < 36; k++) chk_entry($sformatf("init%0d", k), k, k, 32'h20);

    // 'A','B' back to back
    log_reset();
    send(7'h41, h1);
    send(7'h42, h2);
    repeat (2) @(posedge clk);
    #1;
    chk("ab_nwrites", log_addr.size(), 2);
    chk_entry("ab0", 0, 0, 32'h41);
    chk_entry("ab1", 1, 1, 32'h42);
    if (log_cyc.size() >= 2) begin
      chk("ab0_lat", log_cyc[0], h1 + 1);
      chk("ab1_lat", log_cyc[1], h2 + 1);
    end else begin
      chk("ab_lat_missing", log_cyc.size(), 2);
    end
    chk("ab_gap", h2 - h1, 2);
    chk("ab_cursor", 32'(cursor_pos), 2);

    // CR and ignored code are zero-cost, then 12 chars, CR, BS at col 0
    log_reset();
    send(7'h0D, h);
    chk("cr_ready", 32'(bus.in_ready), 1);
    chk("cr_cursor", 32'(cursor_pos), 0);
    send(7'h01, h);
    chk("ign_ready", 32'(bus.in_ready), 1);
    chk("ign_nwrites", log_addr.size(), 0);
    for (int k = 0; k < 12; k++) send(7'(7'h61 + k), h);
    wait_ready(10, n);
    chk("row_cursor", 32'(cursor_pos), 12);
    send(7'h0D, h);
    chk("cr0_cursor", 32'(cursor_pos), 12);
    send(7'h08, h);
    chk("bs0_ready", 32'(bus.in_ready), 1);
    chk("bs0_cursor", 32'(cursor_pos), 12);
    @(posedge clk); #1;
    chk("row_nwrites", log_addr.size(), 12);
    for (int k = 0; k < 12; k++) chk_entry($sformatf("row%0d", k), k, k, 32'h61 + k);
    send(7'h78, h);
    send(7'h08, h);
    wait_ready(10, n);
    chk_entry("x_wr", 12, 12, 32'h78);
    chk_entry("bs_wr", 13, 12, 32'h20);
    chk("bs_cursor", 32'(cursor_pos), 12);

    // clear wins over a simultaneous offer
    bus.in_char  = 7'h55;
    bus.in_valid = 1'b1;
    clear        = 1'b1;
    #1;
    chk("clr_prio_ready", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    log_reset();
    wait_ready(100, n);
    chk("clr_edges", n, 36);
    chk("clr_cursor", 32'(cursor_pos), 0);
    chk("clr_nwrites", log_addr.size(), 36);
    for (int k = 0; k < 36; k++) chk_entry($sformatf("clr%0d", k), k, k, 32'h20);

    // fill the screen, last char triggers a scroll
    log_reset();
    for (int k = 0; k < 36; k++) send(7'(7'h41 + k), h);
    wait_ready(100, n);
    chk("fill_ready_low", n, 37);
    chk("fill_cursor", 32'(cursor_pos), 24);
    chk("fill_nwrites", log_addr.size(), 72);
    chk_entry("fill_last", 35, 35, 32'h64);
    for (int k = 0; k < 24; k++) chk_entry($sformatf("scr_cp%0d", k), 36 + k, k, 32'h4D + k);
    for (int k = 0; k < 12; k++) chk_entry($sformatf("scr_bl%0d", k), 60 + k, 24 + k, 32'h20);

    // LF on last row scrolls with no WRITE cycle
    log_reset();
    send(7'h0A, h);
    wait_ready(100, n);
    chk("lf_ready_low", n, 36);
    chk("lf_nwrites", log_addr.size(), 36);
    chk_entry("lf_cp0", 0, 0, 32'h59);
    chk_entry("lf_cp12", 12, 12, 32'h20);
    if (log_cyc.size() > 0) chk("lf_lat", log_cyc[0], h + 1);
    else chk("lf_lat_missing", log_cyc.size(), 1);
    chk("lf_cursor", 32'(cursor_pos), 24);

    // clear during COPY cycle 10 aborts the scroll
    log_reset();
    send(7'h0A, h);
    repeat (9) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("abort_ncopy", log_addr.size(), 10);
    log_reset();
    wait_ready(100, n);
    chk("abort_edges", n, 36);
    chk("abort_cursor", 32'(cursor_pos), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_nwrites", log_addr.size(), 36);
    for (int k = 0; k < 36; k++) chk_entry($sformatf("abort%0d", k), k, k, 32'h20);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_quiet", log_addr.size(), 36);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vgacon_term_ctrl.md
# vgacon_term_ctrl

Terminal-style write sequencer for the VGA text console's 12×3 character buffer. It accepts a stream of 7-bit character codes over a valid/ready handshake. It owns the buffer's single write port and tracks a cursor. It interprets CR, LF and BS, wraps at end of line, and scrolls the screen up one row by copying buffer contents through the buffer read port. It sits between the CPU-facing register interface and the text RAM read by the character renderer.

## Interface
Parameters:
- COLS, 12, characters per row
- ROWS, 3, rows on screen; COLS*ROWS ≤ 64
- BLANK, 7'h20, fill code for cleared cells

Ports:
- clk  in  1  system clock (64 MHz)
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  character offered
- in_char  in  7  character code
- in_ready  out  1  block accepts in_char this cycle
- clear  in  1  one-cycle pulse: blank screen, home cursor
- buf_we  out  1  text buffer write enable
- buf_addr  out  6  text buffer write address (row*COLS+col)
- buf_wdata  out  7  text buffer write data
- buf_raddr  out  6  text buffer read address
- buf_rdata  in  7  text buffer read data, combinational from buf_raddr
- cursor_pos  out  6  current cursor cell, for renderer cursor overlay
- busy  out  1  high in any state other than IDLE

## Operation
- States:
  - INIT: reset state; always → CLEAR next cycle.
  - IDLE
  - WRITE: one cycle, commits the latched printable character.
  - COPY: scroll copy.
  - FILL: blank the last row.
  - CLEAR: blank all cells.
- A handshake occurs when in_valid & in_ready. in_ready = (state==IDLE) & ~clear.
- Handling by code, in IDLE on handshake:
  - 0x20–0x7E: latch the code → WRITE. WRITE writes it at cursor_pos, then advances the cursor.
    - col<COLS-1: col+1, → IDLE.
    - Otherwise col=0. If row<ROWS-1: row+1, → IDLE. Else → COPY.
  - 0x0D (CR): col=0, stay IDLE.
  - 0x0A (LF): col=0. If row<ROWS-1: row+1, stay IDLE. Else → COPY.
  - 0x08 (BS): if col>0, col-1 and → WRITE with BLANK at the new cell; the cursor does not advance after this write. If col=0, no effect.
  - Any other code is accepted and ignored.
- COPY: counter i runs 0..(ROWS-1)*COLS-1 (24 cycles at default).
  - buf_raddr = i+COLS; buf_we=1, buf_addr=i, buf_wdata=buf_rdata.
  - Then → FILL.
- FILL: counter i runs (ROWS-1)*COLS..ROWS*COLS-1 (12 cycles).
  - buf_we=1, buf_addr=i, buf_wdata=BLANK.
  - Cursor stays row ROWS-1, col 0. Then → IDLE.
- CLEAR: counter i runs 0..ROWS*COLS-1 (36 cycles), writing BLANK at i. Cursor set to 0 on entry. Then → IDLE.
- clear is sampled in every state except INIT. It forces → CLEAR with i=0 next cycle and aborts any COPY, FILL or WRITE in progress; a pending WRITE is dropped. clear has priority over a simultaneous handshake, because in_ready is low that cycle.
- Outside WRITE, COPY, FILL and CLEAR: buf_we=0. buf_addr and buf_wdata are don't-care; buf_raddr=0.
- buf_* outputs are combinational from registered state, counter and buf_rdata only. There is no combinational path from in_* or clear.

## Timing
- Reset (asynchronous): state=INIT, cursor_pos=0, counter=0, latched char=BLANK. Outputs: buf_we=0, in_ready=0, busy=1.
- After reset deasserts: 1 cycle INIT, then 36 cycles CLEAR. in_ready first rises on cycle 38.
- Printable character accepted at edge T: written at edge T+1. in_ready low for 1 cycle.
- CR, LF without scroll, and ignored codes: zero-cost; in_ready stays high, so back-to-back acceptance is allowed.
- Scroll by LF accepted at T: COPY during T+1..T+24, FILL during T+25..T+36, in_ready high at T+37.
- Scroll by a printable character at cell 35: WRITE at T+1, COPY T+2..T+25, FILL T+26..T+37, in_ready at T+38.
- cursor_pos updates on the same edge that completes the operation.

## Structure
- Shared package vgacon_pkg holds:
  - the state enum (INIT, IDLE, WRITE, COPY, FILL, CLEAR)
  - constants CH_CR=7'h0D, CH_LF=7'h0A, CH_BS=7'h08, CH_BLANK=7'h20
  - default COLS and ROWS, also used by the renderer
- Single module; no sub-module. The cursor is held as separate row and col counters; cursor_pos = row*COLS+col, computed with a constant-multiply adder.

## Test plan
- Reset release: 36 writes of 0x20 to addresses 0..35 in order, then in_ready=1 and cursor_pos=0.
- Send 'A','B' (0x41,0x42) back-to-back: writes 0x41@0 then 0x42@1, each one cycle after its handshake; cursor_pos=2.
- Send 12 printable characters, then CR, then BS: writes to 0..11; cursor_pos goes 12→12 (CR at col 0 is a no-op) → 12; BS at col 0 produces no write.
- Fill the screen with codes 0x41..0x64 (36 characters): the last write (0x64@35) is followed by 24 copy writes (addr i receives old value at i+12, e.g. 0x4D@0) and 12 writes of 0x20@24..35; cursor_pos=24; in_ready low for exactly 37 cycles.
- LF on row 2: scroll starts the cycle after the handshake, with no WRITE cycle.
- clear pulsed mid-COPY (cycle 10): the copy aborts, the next 36 writes are 0x20@0..35, cursor_pos=0, and no further copy writes occur.
